// File: rtl/modmul_sched_pkg.sv
// Shared definitions for the modular-multiplier scheduler: datapath parameter set,
// latency helper and the scheduler FSM state type.
package modmul_sched_pkg;

  typedef struct packed {
    int unsigned logq;
    int unsigned logqh;
  } modmul_params_t;

  localparam modmul_params_t MODMUL_PARAMS = '{logq: 32, logqh: 15};

  // Input register, multiply, reduce, output register; wider moduli get one retiming stage more.
  function automatic int modmul_lat(input modmul_params_t p);
    return (p.logq > 32) ? 5 : 4;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

endpackage

// File: rtl/modmul.sv
// Fully pipelined A*B mod q, LAT cycles from operands to t (LAT >= 4), never stalls.
module modmul #(
  parameter int LOGQ    = 32,
  parameter int LAT     = 4,
  parameter bit CORRECT = 1'b1
) (
  input  logic            clk,
  input  logic [LOGQ-1:0] a,
  input  logic [LOGQ-1:0] b,
  input  logic [LOGQ-1:0] q,
  output logic [LOGQ-1:0] t
);

  localparam int ND = LAT - 3;

  logic [LOGQ-1:0]   s1_a, s1_b, s1_q, s2_q, s3_r, red;
  logic [2*LOGQ-1:0] s2_p;
  logic [LOGQ-1:0]   dly [ND];

  // CORRECT=0 passes the raw low product word, useful only for datapath bring-up.
  generate
    if (CORRECT) begin : g_full
      assign red = LOGQ'(s2_p % {{LOGQ{1'b0}}, s2_q});
    end else begin : g_raw
      assign red = s2_p[LOGQ-1:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    s1_a   <= a;
    s1_b   <= b;
    s1_q   <= q;
    s2_p   <= {{LOGQ{1'b0}}, s1_a} * {{LOGQ{1'b0}}, s1_b};
    s2_q   <= s1_q;
    s3_r   <= red;
    dly[0] <= s3_r;
    for (int i = 1; i < ND; i++) dly[i] <= dly[i-1];
  end

  assign t = dly[ND-1];

endmodule

// File: rtl/modmul_sched.sv
// Round-robin issue of NREQ requesters into one pipelined modmul, with tag tracking,
// in-flight counting, flush/drain and a qH config register writable only when idle.
// Handshake: a requester transfers when req_valid[i] && req_ready[i]; req_ready is a
// combinational one-hot grant that is never raised for a requester whose valid is low.
module modmul_sched
  import modmul_sched_pkg::*;
#(
  parameter int LOGQ  = 32,
  parameter int LOGQH = 15,
  parameter int NREQ  = 4,
  parameter int LAT   = modmul_lat(MODMUL_PARAMS),
  localparam int IDW  = ($clog2(NREQ) < 1) ? 1 : $clog2(NREQ),
  localparam int CW   = $clog2(LAT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*LOGQ-1:0] req_a,
  input  logic [NREQ*LOGQ-1:0] req_b,
  input  logic               cfg_we,
  input  logic [LOGQH-1:0]   cfg_qh,
  output logic               cfg_ready,
  input  logic               flush,
  output logic               flush_done,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic [LOGQ-1:0]    rsp_t,
  output logic               busy
);

  sched_state_t    state, state_next;
  logic [CW-1:0]   count, count_next;
  logic [IDW-1:0]  ptr, gnt_id;
  logic            gnt_hit, cfg_accept, issue_ok, issue, retire;
  logic [LOGQH-1:0] qh;
  logic [LOGQ-1:0] q, a_sel, b_sel;
  logic            tag_v  [LAT];
  logic [IDW-1:0]  tag_id [LAT];

  // Config write wins over issue in the same cycle so qH never changes under a live op.
  assign cfg_ready  = !rst && (state == IDLE) && (count == '0) && !flush;
  assign cfg_accept = cfg_we && cfg_ready;
  assign issue_ok   = !rst && !flush && (state != DRAIN) && !cfg_accept;

  always_comb begin
    gnt_hit = 1'b0;
    gnt_id  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!gnt_hit && req_valid[(int'(ptr) + k) % NREQ]) begin
        gnt_hit = 1'b1;
        gnt_id  = IDW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  assign issue      = issue_ok && gnt_hit;
  assign req_ready  = issue ? (NREQ'(1) << gnt_id) : '0;
  assign retire     = tag_v[LAT-1];
  assign count_next = count + CW'(issue) - CW'(retire);

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = DRAIN;
    end else begin
      case (state)
        IDLE:    if (issue) state_next = RUN;
        RUN:     if (count_next == '0) state_next = IDLE;
        DRAIN:   state_next = (count == '0) ? IDLE : RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      ptr   <= IDW'(NREQ - 1);
      qh    <= '0;
      for (int i = 0; i < LAT; i++) tag_v[i] <= 1'b0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      tag_v[0] <= issue;
      for (int i = 1; i < LAT; i++) tag_v[i] <= tag_v[i-1];
      if (issue) ptr <= gnt_id;
      if (cfg_accept) qh <= cfg_qh;
    end
  end

  always_ff @(posedge clk) begin
    tag_id[0] <= gnt_id;
    for (int i = 1; i < LAT; i++) tag_id[i] <= tag_id[i-1];
  end

  assign q     = {qh, {(LOGQ-LOGQH){1'b0}}} + LOGQ'(1);
  assign a_sel = req_a[int'(gnt_id)*LOGQ +: LOGQ];
  assign b_sel = req_b[int'(gnt_id)*LOGQ +: LOGQ];

  modmul #(.LOGQ(LOGQ), .LAT(LAT), .CORRECT(1'b1)) u_modmul (
    .clk (clk),
    .a   (a_sel),
    .b   (b_sel),
    .q   (q),
    .t   (rsp_t)
  );

  assign rsp_valid  = !rst && tag_v[LAT-1];
  assign rsp_id     = rsp_valid ? tag_id[LAT-1] : '0;
  assign busy       = !rst && (count != '0);
  assign flush_done = !rst && flush && (count == '0);

endmodule

// File: tb/tb_modmul_sched.sv
// Directed bench for modmul_sched: reset, single op, modular wrap, round-robin,
// config gating, flush/drain and mid-operation reset.
module tb_modmul_sched;

  localparam int LOGQ = 32, LOGQH = 15, NREQ = 4, LAT = 4, IDW = 2;

  logic                 clk, rst, cfg_we, cfg_ready, flush, flush_done;
  logic                 rsp_valid, busy;
  logic [NREQ-1:0]      req_valid, req_ready;
  logic [NREQ*LOGQ-1:0] req_a, req_b;
  logic [LOGQH-1:0]     cfg_qh;
  logic [IDW-1:0]       rsp_id;
  logic [LOGQ-1:0]      rsp_t;

  int n_vec = 0, n_err = 0, cyc = 0;
  int xfer_cyc[$], xfer_id[$], rsp_cyc[$], rsp_id_q[$];
  logic [LOGQ-1:0] rsp_t_q[$];
  logic [LOGQ-1:0] exp_q[$];

  modmul_sched #(.LOGQ(LOGQ), .LOGQH(LOGQH), .NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .cfg_we(cfg_we), .cfg_qh(cfg_qh),
    .cfg_ready(cfg_ready), .flush(flush), .flush_done(flush_done),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_t(rsp_t), .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time budget exceeded");
    $fatal(1);
  end

  // monitor: logs transfers/responses and checks the one-hot, valid-qualified grant
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREQ; i++)
        if (req_valid[i] && req_ready[i]) begin
          xfer_cyc.push_back(cyc);
          xfer_id.push_back(i);
        end
      if (rsp_valid) begin
        rsp_cyc.push_back(cyc);
        rsp_id_q.push_back(int'(rsp_id));
        rsp_t_q.push_back(rsp_t);
      end
      n_vec++;
      if ((req_ready & ~req_valid) != '0 || $countones(req_ready) > 1) begin
        n_err++;
        $display("FAIL grant_shape: req_ready=%b req_valid=%b", req_ready, req_valid);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    xfer_cyc.delete(); xfer_id.delete(); rsp_cyc.delete();
    rsp_id_q.delete(); rsp_t_q.delete(); exp_q.delete();
  endtask

  task automatic set_op(input int i, input logic [LOGQ-1:0] a, input logic [LOGQ-1:0] b);
    req_a[i*LOGQ +: LOGQ] = a;
    req_b[i*LOGQ +: LOGQ] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; cfg_we = 1'b0; flush = 1'b0;
    tick(); tick();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic cfg_write(input logic [LOGQH-1:0] v);
    cfg_we = 1'b1; cfg_qh = v;
    @(negedge clk);
    n_vec++;
    if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL cfg_write: cfg_ready=%b want 1", cfg_ready); end
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy === 1'b1 && k < budget) begin tick(); k++; end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL wait_idle: busy=%b after %0d cycles want 0", busy, budget); end
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1; req_valid = '1; cfg_we = 1'b1; cfg_qh = 15'h1234; flush = 1'b0;
    req_a = '0; req_b = '0;
    tick();
    @(negedge clk);
    n_vec++;
    if ({req_ready, rsp_valid, rsp_id, busy, flush_done, cfg_ready} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: ready=%b rv=%b id=%0d busy=%b fd=%b cr=%b want all 0",
               req_ready, rsp_valid, rsp_id, busy, flush_done, cfg_ready);
    end
    tick();
    rst = 1'b0; req_valid = '0; cfg_we = 1'b0;
    @(negedge clk);
    n_vec++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL post_reset: cfg_ready=%b busy=%b want 1/0", cfg_ready, busy);
    end
    tick();
    clear_logs();
  endtask

  task automatic test_single();
    cfg_write(15'd1);
    clear_logs();
    set_op(0, 32'd3, 32'd5);
    req_valid = 4'b0001;
    @(negedge clk);
    n_vec++;
    if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_grant: req_ready=%b want 0001", req_ready); end
    tick();
    req_valid = '0;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: busy=%b want 1", busy); end
    tick();
    repeat (6) tick();
    n_vec++;
    if (rsp_t_q.size() != 1 || xfer_cyc.size() != 1) begin
      n_err++; $display("FAIL single_count: rsp=%0d xfer=%0d want 1/1", rsp_t_q.size(), xfer_cyc.size());
    end else begin
      n_vec++;
      if (rsp_cyc[0] - xfer_cyc[0] != LAT) begin
        n_err++; $display("FAIL single_latency: got %0d want %0d", rsp_cyc[0] - xfer_cyc[0], LAT);
      end
      n_vec++;
      if (rsp_id_q[0] != 0 || rsp_t_q[0] !== 32'd15) begin
        n_err++; $display("FAIL single_result: id=%0d t=%0d want 0/15", rsp_id_q[0], rsp_t_q[0]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [LOGQ-1:0] want [4];
    want[0] = 32'd1; want[1] = 32'd0; want[2] = 32'hFFFD_FFFF; want[3] = 32'h0001_FFFF;
    clear_logs();
    set_op(1, 32'd131072, 32'd131072);
    req_valid = 4'b0010;
    tick();
    set_op(1, 32'd0, 32'd77);
    tick();
    req_valid = '0;
    wait_idle(12);
    cfg_write(15'h7FFF);
    set_op(2, 32'hFFFE_0000, 32'd2);
    req_valid = 4'b0100;
    tick();
    set_op(2, 32'h0001_0000, 32'h0001_0000);
    tick();
    req_valid = '0;
    wait_idle(12);
    n_vec++;
    if (rsp_t_q.size() != 4) begin
      n_err++; $display("FAIL wrap_count: got %0d want 4", rsp_t_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_vec++;
        if (rsp_t_q[k] !== want[k] || rsp_id_q[k] != ((k < 2) ? 1 : 2)) begin
          n_err++; $display("FAIL wrap_%0d: t=%h id=%0d want t=%h id=%0d", k, rsp_t_q[k], rsp_id_q[k],
                            want[k], (k < 2) ? 1 : 2);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    cfg_write(15'd1);
    clear_logs();
    for (int i = 0; i < NREQ; i++) set_op(i, 32'(i + 2), 32'd10);
    for (int k = 0; k < 8; k++) exp_q.push_back(32'(((k % NREQ) + 2) * 10));
    req_valid = 4'hF;
    repeat (8) tick();
    req_valid = '0;
    wait_idle(12);
    n_vec++;
    if (xfer_cyc.size() != 8 || rsp_t_q.size() != 8) begin
      n_err++; $display("FAIL rr_count: xfer=%0d rsp=%0d want 8/8", xfer_cyc.size(), rsp_t_q.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        n_vec++;
        if (xfer_id[k] != k % NREQ || xfer_cyc[k] != xfer_cyc[0] + k) begin
          n_err++; $display("FAIL rr_grant_%0d: id=%0d cyc_off=%0d want id=%0d cyc_off=%0d",
                            k, xfer_id[k], xfer_cyc[k] - xfer_cyc[0], k % NREQ, k);
        end
        n_vec++;
        if (rsp_id_q[k] != k % NREQ || rsp_cyc[k] != xfer_cyc[k] + LAT || rsp_t_q[k] !== exp_q[k]) begin
          n_err++; $display("FAIL rr_rsp_%0d: id=%0d lat=%0d t=%0d want id=%0d lat=%0d t=%0d", k,
                            rsp_id_q[k], rsp_cyc[k] - xfer_cyc[k], rsp_t_q[k], k % NREQ, LAT, exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_cfg_busy();
    clear_logs();
    set_op(0, 32'd131072, 32'd131072);
    req_valid = 4'b0001;
    tick();
    req_valid = '0; cfg_we = 1'b1; cfg_qh = 15'd5;
    @(negedge clk);
    n_vec++;
    if (cfg_ready !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL cfg_busy_gate: cfg_ready=%b busy=%b want 0/1", cfg_ready, busy);
    end
    tick();
    set_op(0, 32'd131072, 32'd2);
    req_valid = 4'b0001;
    @(negedge clk);
    n_vec++;
    if (cfg_ready !== 1'b0 || req_ready !== 4'b0001) begin
      n_err++; $display("FAIL cfg_busy_issue: cfg_ready=%b req_ready=%b want 0/0001", cfg_ready, req_ready);
    end
    tick();
    req_valid = '0; cfg_we = 1'b0;
    wait_idle(12);
    n_vec++;
    if (rsp_t_q.size() != 2 || rsp_t_q[0] !== 32'd1 || rsp_t_q[1] !== 32'd131071) begin
      n_err++; $display("FAIL cfg_qh_stable: n=%0d t0=%0d t1=%0d want 2/1/131071",
                        rsp_t_q.size(), rsp_t_q[0], rsp_t_q[1]);
    end
    cfg_we = 1'b1; cfg_qh = 15'd2;
    set_op(0, 32'd262144, 32'd262144);
    req_valid = 4'b0001;
    @(negedge clk);
    n_vec++;
    if (cfg_ready !== 1'b1 || req_ready !== 4'b0000) begin
      n_err++; $display("FAIL cfg_accept: cfg_ready=%b req_ready=%b want 1/0000", cfg_ready, req_ready);
    end
    tick();
    cfg_we = 1'b0;
    @(negedge clk);
    n_vec++;
    if (req_ready !== 4'b0001) begin n_err++; $display("FAIL cfg_after_grant: req_ready=%b want 0001", req_ready); end
    tick();
    req_valid = '0;
    wait_idle(12);
    n_vec++;
    if (rsp_t_q.size() != 3 || rsp_t_q[2] !== 32'd1) begin
      n_err++; $display("FAIL cfg_new_q: n=%0d t=%0d want 3/1", rsp_t_q.size(), rsp_t_q[2]);
    end
  endtask

  task automatic test_flush();
    int  first_done = -1;
    bit  bad_ready = 1'b0;
    clear_logs();
    set_op(3, 32'd7, 32'd9);
    req_valid = 4'b1000;
    repeat (3) tick();
    flush = 1'b1; req_valid = 4'hF;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (req_ready !== '0) bad_ready = 1'b1;
      if (flush_done === 1'b1 && first_done < 0) first_done = cyc;
      tick();
    end
    n_vec++;
    if (bad_ready) begin n_err++; $display("FAIL flush_ready: req_ready=1 during flush want 0"); end
    n_vec++;
    if (xfer_cyc.size() != 3 || rsp_t_q.size() != 3) begin
      n_err++; $display("FAIL flush_count: xfer=%0d rsp=%0d want 3/3", xfer_cyc.size(), rsp_t_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (rsp_t_q[k] !== 32'd63 || rsp_id_q[k] != 3) begin
          n_err++; $display("FAIL flush_rsp_%0d: t=%0d id=%0d want 63/3", k, rsp_t_q[k], rsp_id_q[k]);
        end
      end
      n_vec++;
      if (first_done != xfer_cyc[2] + LAT + 1) begin
        n_err++; $display("FAIL flush_done_time: cyc=%0d want %0d", first_done, xfer_cyc[2] + LAT + 1);
      end
    end
    flush = 1'b0; req_valid = '0;
    tick();
    @(negedge clk);
    n_vec++;
    if (cfg_ready !== 1'b1 || flush_done !== 1'b0) begin
      n_err++; $display("FAIL flush_exit: cfg_ready=%b flush_done=%b want 1/0", cfg_ready, flush_done);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    clear_logs();
    set_op(2, 32'd3, 32'd5);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    tick();
    rst = 1'b1; req_valid = 4'hF;
    @(negedge clk);
    n_vec++;
    if ({req_ready, rsp_valid, rsp_id, busy, flush_done, cfg_ready} !== '0) begin
      n_err++; $display("FAIL midreset_outputs: ready=%b rv=%b busy=%b cr=%b want all 0",
                        req_ready, rsp_valid, busy, cfg_ready);
    end
    tick();
    rst = 1'b0; req_valid = '0;
    repeat (8) tick();
    @(negedge clk);
    n_vec++;
    if (rsp_t_q.size() != 0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
      n_err++; $display("FAIL midreset_quiet: rsp=%0d busy=%b cfg_ready=%b want 0/0/1",
                        rsp_t_q.size(), busy, cfg_ready);
    end
    tick();
    clear_logs();
    cfg_write(15'd1);
    for (int i = 0; i < NREQ; i++) set_op(i, 32'd4, 32'd6);
    req_valid = 4'hF;
    @(negedge clk);
    n_vec++;
    if (req_ready !== 4'b0001) begin n_err++; $display("FAIL midreset_first: req_ready=%b want 0001", req_ready); end
    tick();
    req_valid = '0;
    wait_idle(12);
    n_vec++;
    if (rsp_t_q.size() != 1 || rsp_id_q[0] != 0 || rsp_t_q[0] !== 32'd24) begin
      n_err++; $display("FAIL midreset_next: n=%0d id=%0d t=%0d want 1/0/24",
                        rsp_t_q.size(), rsp_id_q[0], rsp_t_q[0]);
    end
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_cfg_busy();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/modmul_sched.md
MODMUL_SCHED -- requirements
Module: modmul_sched

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter LOGQ, default 32: operand and modulus width.
REQ-002 The block SHALL have parameter LOGQH, default 15: width of qH; the modulus is q = qH*2^(LOGQ-LOGQH)+1.
REQ-003 The block SHALL have parameter NREQ, default 4: number of requesters, range 2..16.
REQ-004 The block SHALL have parameter LAT, default modmul_lat() of the package parameter set: modmul latency in cycles.
REQ-005 The block SHALL set IDW = max(1, clog2(NREQ)) and CW = clog2(LAT+1).

Ports (name, direction, width, meaning):
REQ-006 clk  in  1  clock. Single clock; all state updates on its rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 req_valid  in  NREQ  per-requester operand valid.
REQ-009 req_ready  out  NREQ  per-requester grant; transfer when valid&&ready.
REQ-010 req_a, req_b  in  NREQ*LOGQ each  operands; requester i uses slice [i*LOGQ +: LOGQ].
REQ-011 cfg_we, cfg_qh, cfg_ready  in 1, in LOGQH, out 1  qH write request, value, and accept-permitted.
REQ-012 flush  in  1  level: stop issuing and drain the pipeline.
REQ-013 flush_done  out  1  high while flush && pipeline empty.
REQ-014 rsp_valid, rsp_id, rsp_t  out 1, IDW, LOGQ  result strobe, owning requester, A*B mod q.
REQ-015 busy  out  1  in-flight count nonzero.

Function
REQ-016 The block SHALL issue at most one operation per cycle into one fully pipelined modmul instance; the pipeline never stalls.
REQ-017 Arbitration SHALL be round-robin: search starts at (last granted + 1) mod NREQ; the pointer advances only on an actual transfer.
REQ-018 At most one req_ready bit SHALL be high per cycle; req_ready[i] may depend combinationally on req_valid, and SHALL be zero for requesters with req_valid low.
REQ-019 The FSM states SHALL be IDLE (count==0), RUN (count>0), DRAIN (flush high).
REQ-020 FSM transitions: IDLE->RUN on issue; RUN->IDLE when count reaches 0 with no issue; any state->DRAIN when flush=1; DRAIN->IDLE when flush=0 and count==0; DRAIN->RUN when flush=0 and count>0.
REQ-021 In DRAIN, all req_ready bits SHALL be 0 while in-flight results continue to emerge.
REQ-022 cfg_ready SHALL be high only in IDLE with count==0 and flush=0.
REQ-023 cfg_we with cfg_ready SHALL load the qH register on that edge; no grant SHALL occur in that cycle, since cfg has priority over issue.
REQ-024 cfg_we without cfg_ready SHALL be ignored; qH SHALL remain stable while any operation is in flight.
REQ-025 A LAT-deep tag shift register SHALL carry {valid, id} alongside the datapath; rsp_valid/rsp_id SHALL appear exactly LAT cycles after the transfer cycle, aligned with rsp_t.
REQ-026 The in-flight counter SHALL use the rule count_next = count + issue - retire, where simultaneous issue and retire leave it unchanged; it SHALL never exceed LAT.
REQ-027 rsp_t SHALL be fully reduced (0..q-1); operands are required to be < q, and out-of-range operands give an undefined rsp_t but correct rsp_valid/rsp_id.
REQ-028 rsp_t SHALL be don't-care when rsp_valid=0; it is not required to hold its value.

Reset
REQ-029 On rst: FSM=IDLE, count=0, RR pointer=NREQ-1 (so requester 0 wins first), all tag valids=0, qH register=0.
REQ-030 On rst: req_ready=0, rsp_valid=0, rsp_id=0, busy=0, flush_done=0, cfg_ready=0 during the reset cycle.
REQ-031 Reset mid-operation SHALL discard all in-flight tags; no rsp_valid SHALL appear after reset from pre-reset issues, and datapath registers need no reset.

Structure
REQ-032 The shared modmul package SHALL hold modmul_params_t, modmul_lat(), and the new typedef sched_state_t {IDLE, RUN, DRAIN}.
REQ-033 The single sub-module SHALL be modmul, instantiated with CORRECT=1; the round-robin arbiter stays inline.

Verification
REQ-034 Single op: qH=1 (q=131073), req0 A=3 B=5 -> rsp_valid exactly LAT cycles later, rsp_id=0, rsp_t=15.
REQ-035 All four req_valid held high for 8 cycles -> grant order 0,1,2,3,0,1,2,3, back-to-back, and 8 responses in the same order.
REQ-036 Wrap case: A=B=q-1 with qH=1 -> rsp_t=1; A=0 -> rsp_t=0.
REQ-037 cfg_we asserted while busy -> cfg_ready=0 and qH unchanged; retry after drain -> accepted, with no grant in the accept cycle.
REQ-038 flush with 3 ops in flight -> req_ready=0, the 3 responses still emerge, flush_done rises the cycle count hits 0.
REQ-039 rst pulsed 2 cycles after issue -> no rsp_valid ever appears, all outputs at reset values, and the next issue works.
